iob_cache_perf_ctrl: RTL

- Parametrised cache control/performance block for the cache's CSR slave port.
- Counts NUM_EVT cache events in CNT_W-bit counters with per-event enable, freeze and sticky overflow flags.
- Sequences a cache invalidate through a drain/request/acknowledge state machine so the write-through buffer is empty before the invalidate pulse is issued.
- Sits between the cache front-end CSR decoder and the cache core / write-through buffer.

---
 rtl/iob_cache_perf_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/iob_cache_perf_ctrl.sv
// Cache CSR block: event counters with enable/freeze/overflow and invalidate sequencing.
// Optional IOB_CACHE_PERF_SATURATE_EN makes counters saturate instead of wrapping.
module iob_cache_perf_ctrl #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 6,
    parameter int          NUM_EVT = 4,
    parameter int          CNT_W   = 32,
    parameter logic [15:0] VERSION = 16'h0100
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_n_i,
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ready_o,
    input  logic [NUM_EVT-1:0]  evt_i,
    input  logic                wtbuf_empty_i,
    input  logic                wtbuf_full_i,
    output logic                invalidate_o,
    input  logic                invalidate_ack_i
);

    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WI_W   = ADDR_W - BYTE_W;

    localparam logic [WI_W-1:0] A_CTRL = WI_W'(0);
    localparam logic [WI_W-1:0] A_STAT = WI_W'(1);
    localparam logic [WI_W-1:0] A_EN   = WI_W'(2);
    localparam logic [WI_W-1:0] A_OVF  = WI_W'(3);
    localparam logic [WI_W-1:0] A_VER  = WI_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state_q;
    logic               inv_q;
    logic               ready_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [CNT_W-1:0]   cnt_q [NUM_EVT];
    logic [CNT_W-1:0]   cnt_d [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_q;
    logic [NUM_EVT-1:0] ovf_d;
    logic [NUM_EVT-1:0] en_q;
    logic               frz_q;

    logic [WI_W-1:0]    widx;
    logic               we;
    logic               wr_ctrl;
    logic               wr_en;
    logic               wr_ovf;
    logic [NUM_EVT-1:0] inc;
    logic [DATA_W-1:0]  rd_val;
    logic               unused_ok;

    assign widx    = addr_i[ADDR_W-1:BYTE_W];
    assign we      = valid_i & (|wstrb_i);
    assign wr_ctrl = we && (widx == A_CTRL);
    assign wr_en   = we && (widx == A_EN);
    assign wr_ovf  = we && (widx == A_OVF);
    assign inc     = evt_i & en_q & {NUM_EVT{~frz_q}};

    assign unused_ok = ^{addr_i[BYTE_W-1:0], wdata_i};

    always_comb begin
        rd_val = '0;
        case (widx)
            A_CTRL:  rd_val[0]   = frz_q;
            A_STAT:  rd_val[3:0] = {|ovf_q, state_q != S_IDLE,
                                    wtbuf_full_i, wtbuf_empty_i};
            A_EN:    rd_val[NUM_EVT-1:0] = en_q;
            A_OVF:   rd_val[NUM_EVT-1:0] = ovf_q;
            A_VER:   rd_val[15:0] = VERSION;
            default: ;
        endcase
        // Counters live at word 8 onward, only when the index space reaches them
        for (int i = 0; i < NUM_EVT; i++) begin
            if ((8 + i) < (1 << WI_W) && widx == WI_W'(8 + i)) begin
                rd_val[CNT_W-1:0] = cnt_q[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (wr_ovf && wdata_i[i]) ovf_d[i] = 1'b0;
            if (inc[i]) begin
                if (&cnt_q[i]) ovf_d[i] = 1'b1;
`ifdef IOB_CACHE_PERF_SATURATE_EN
                if (!(&cnt_q[i])) cnt_d[i] = cnt_q[i] + 1'b1;
`else
                cnt_d[i] = cnt_q[i] + 1'b1;
`endif
            end
        end
        if (wr_ctrl && wdata_i[0]) begin
            cnt_d = '{default: '0};
            ovf_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '{default: '0};
            ovf_q   <= '0;
            en_q    <= '1;
            frz_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else if (cke_i) begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= valid_i;
            rdata_q <= (valid_i && !we) ? rd_val : '0;
            if (wr_ctrl) frz_q <= wdata_i[2];
            if (wr_en && wstrb_i[0]) en_q <= wdata_i[NUM_EVT-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            inv_q   <= 1'b0;
        end else if (cke_i) begin
            inv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_ctrl && wdata_i[1]) begin
                        if (wtbuf_empty_i) begin
                            state_q <= S_ISSUE;
                            inv_q   <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (wtbuf_empty_i) begin
                        state_q <= S_ISSUE;
                        inv_q   <= 1'b1;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT:  if (invalidate_ack_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata_o      = rdata_q;
    assign ready_o      = ready_q;
    assign invalidate_o = inv_q;

endmodule
